// File: rtl/aes_round_tail.sv
// aes_round_tail: ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey.
// Two-stage registered pipeline with valid/ready flow control at one block per cycle.
// Stage 1 holds the mixed state, the round key and the tag. Stage 2 is the output register.
module aes_round_tail #(
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_state,
    input  logic [127:0]       in_key,
    input  logic               in_last,
    input  logic [ROUND_W-1:0] in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_state,
    output logic [ROUND_W-1:0] out_round
);

    // GF(2^8) multiply by 2, using the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Mix a single column. a0 is the top byte, held in bits [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3),
                (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte k sits at [127-8k -: 8] and maps to row k%4, column k/4.
    // Each row r is rotated left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    // A column is four consecutive bytes, so it is one 32-bit slice of the state.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    logic [127:0]       sm_q, sm_d;
    logic [127:0]       key_q, key_d;
    logic [ROUND_W-1:0] round1_q, round1_d;
    logic [127:0]       out_state_q, out_state_d;
    logic [ROUND_W-1:0] out_round_q, out_round_d;

    logic         s2_adv;
    logic         in_xfer;
    logic [127:0] sr_state;

    // Handshake decode. in_ready depends combinationally on out_ready, so there is no skid buffer.
    always_comb begin
        s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~s1_valid_q | s2_adv;
        in_xfer  = in_valid & in_ready;
        sr_state = shift_rows(in_state);
    end

    // Next-state logic for both stages. Data registers load only on their own transfer.
    // NOTE: every signal gets a default at the top of the block, so no latch is inferred on any path.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        sm_d        = sm_q;
        key_d       = key_q;
        round1_d    = round1_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            sm_d       = in_last ? sr_state : mix_columns(sr_state);
            key_d      = in_key;
            round1_d   = in_round;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d  = 1'b1;
            out_state_d = sm_q ^ key_q;
            out_round_d = round1_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset. In-flight blocks are discarded on reset.
    // NOTE: sequential state uses non-blocking assignments, so every register samples its pre-edge value.
    // NOTE: the data registers are also cleared, so out_state reads as zero right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            sm_q        <= '0;
            key_q       <= '0;
            round1_q    <= '0;
            out_state_q <= '0;
            out_round_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            sm_q        <= sm_d;
            key_q       <= key_d;
            round1_q    <= round1_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_state = out_state_q;
    assign out_round = out_round_q;

endmodule

// File: tb/tb_aes_round_tail.sv
// Self-checking bench for aes_round_tail.
// The stimulus process pushes the expected result of each accepted block into a scoreboard queue.
// A separate monitor pops and compares one entry on every output transfer.
module tb_aes_round_tail;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic [3:0]   in_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;

    aes_round_tail #(.ROUND_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_round (out_round)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        bit           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] COL4 = {4{32'hdb135345}};
    localparam logic [127:0] MC4  = {4{32'h8e4da1bc}};
    localparam logic [127:0] R1_S = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] R1_K = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] R1_O = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
    localparam logic [127:0] FR_S = 128'he9098972_cb31075f_3d327d94_af2e2cb5;
    localparam logic [127:0] FR_K = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] FR_O = 128'h3925841d_02dc09fb_dc118597_196a0b32;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every output transfer against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got state %h round %0d expected none", out_state, out_round);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    pop_cyc.push_back(cyc);
                    check("out_state", out_state, e.st);
                    check("out_round", 128'(out_round), 128'(e.rnd));
                    if (e.lat) check("latency", 128'(cyc - e.acc), 128'd2);
                end
            end
        end
    end

    // Present a block and wait for it to be accepted. Call this just after a rising edge.
    // On return in_valid is still high, so a following send runs back to back.
    task automatic send(input logic [127:0] s, input logic [127:0] k, input bit l, input logic [3:0] r,
                        input logic [127:0] exp_st, input bit lat, output int stalls);
        exp_t e;
        in_valid = 1'b1;
        in_state = s;
        in_key   = k;
        in_last  = l;
        in_round = r;
        stalls   = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.st  = exp_st;
                e.rnd = r;
                e.lat = lat;
                e.acc = cyc;
                sb.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
        end
        check("accept_timeout", 128'(stalls), 128'd0);
        $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        $fatal(1, "accept timeout");
    endtask

    // Drop in_valid and scramble the inputs, which must not affect blocks already in flight.
    task automatic idle();
        in_valid = 1'b0;
        in_state = {4{$urandom()}};
        in_key   = {4{$urandom()}};
        in_last  = ~in_last;
        in_round = 4'($urandom());
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        int st;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_last   = 1'b0;
        in_round  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_out_state", out_state, 128'd0);
        check("reset_out_round", 128'(out_round), 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        // FIPS-197 round 1 with latency check, then the final round and the MixColumns vectors.
        send(R1_S, R1_K, 1'b0, 4'd1, R1_O, 1'b1, st);
        idle();
        drain();
        send(FR_S, FR_K, 1'b1, 4'd10, FR_O, 1'b1, st);
        idle();
        drain();
        send('0, '0, 1'b0, 4'd3, '0, 1'b0, st);
        send(COL4, '0, 1'b0, 4'd4, MC4, 1'b0, st);
        send(COL4, '0, 1'b1, 4'd5, COL4, 1'b0, st);
        idle();
        drain();

        // Throughput: 8 back-to-back blocks
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            logic [127:0] k;
            k = {16{8'(i * 17 + 1)}};
            send(COL4, k, 1'b0, 4'(i), MC4 ^ k, 1'b0, st);
            check("tp_in_ready_held", 128'(st), 128'd0);
        end
        idle();
        drain();
        check("tp_output_count", 128'(pop_cyc.size()), 128'd8);
        if (pop_cyc.size() == 8) begin
            for (int i = 0; i < 7; i++) check("tp_consecutive", 128'(pop_cyc[i+1] - pop_cyc[i]), 128'd1);
        end

        // Backpressure: 2 blocks accepted, the third stalls for 5 cycles
        out_ready = 1'b0;
        send(R1_S, R1_K, 1'b0, 4'd1, R1_O, 1'b0, st);
        send(FR_S, FR_K, 1'b1, 4'd2, FR_O, 1'b0, st);
        in_state = '0;
        in_key   = 128'h0123456789abcdef_fedcba9876543210;
        in_last  = 1'b0;
        in_round = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 128'(in_ready), 128'd0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_stable", out_state, R1_O);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send('0, 128'h0123456789abcdef_fedcba9876543210, 1'b0, 4'd3,
             128'h0123456789abcdef_fedcba9876543210, 1'b0, st);
        idle();
        drain();

        // X data on in_valid while in_ready is low must not corrupt the stalled blocks.
        out_ready = 1'b0;
        send(R1_S, R1_K, 1'b0, 4'd6, R1_O, 1'b0, st);
        send(FR_S, FR_K, 1'b1, 4'd7, FR_O, 1'b0, st);
        in_state = 'x;
        in_key   = 'x;
        in_last  = 1'bx;
        in_round = 'x;
        repeat (3) @(posedge clk);
        #1;
        idle();
        out_ready = 1'b1;
        drain();

        // Reset with both stages full: the blocks are discarded and no stale output appears.
        out_ready = 1'b0;
        send(R1_S, R1_K, 1'b0, 4'd8, R1_O, 1'b0, st);
        send(FR_S, FR_K, 1'b1, 4'd9, FR_O, 1'b0, st);
        idle();
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_state", out_state, 128'd0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Normal operation after the reset
        send(COL4, '0, 1'b0, 4'd12, MC4, 1'b1, st);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
